// File: rtl/pb_wire_pkg.sv
// Shared protobuf wire-format definitions for the field header encoder and parser.
// Contents: wire type and header error encodings, parser state encoding, the
// maximum tag length in bytes, field-type to wire-type mapping, and the
// header classification helpers used when a header completes.
package pb_wire_pkg;

    typedef enum logic [2:0] {
        WT_VARINT = 3'd0,
        WT_I64    = 3'd1,
        WT_LEN    = 3'd2,
        WT_SGROUP = 3'd3,
        WT_EGROUP = 3'd4,
        WT_I32    = 3'd5
    } wire_type_e;

    typedef enum logic [1:0] {
        ERR_OK    = 2'd0,
        ERR_WTYPE = 2'd1,
        ERR_ID0   = 2'd2,
        ERR_LONG  = 2'd3
    } hdr_err_e;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } parse_state_e;

    // Protobuf descriptor field type numbering.
    typedef enum logic [4:0] {
        FT_DOUBLE   = 5'd1,
        FT_FLOAT    = 5'd2,
        FT_INT64    = 5'd3,
        FT_UINT64   = 5'd4,
        FT_INT32    = 5'd5,
        FT_FIXED64  = 5'd6,
        FT_FIXED32  = 5'd7,
        FT_BOOL     = 5'd8,
        FT_STRING   = 5'd9,
        FT_GROUP    = 5'd10,
        FT_MESSAGE  = 5'd11,
        FT_BYTES    = 5'd12,
        FT_UINT32   = 5'd13,
        FT_ENUM     = 5'd14,
        FT_SFIXED32 = 5'd15,
        FT_SFIXED64 = 5'd16,
        FT_SINT32   = 5'd17,
        FT_SINT64   = 5'd18
    } field_type_e;

    // 29-bit field number plus 3-bit wire type, 7 payload bits per byte.
    localparam int MAX_TAG_BYTES = 5;

    function automatic wire_type_e wire_type_of(input field_type_e ft);
        wire_type_e wt;
        case (ft)
            FT_DOUBLE, FT_FIXED64, FT_SFIXED64: wt = WT_I64;
            FT_FLOAT, FT_FIXED32, FT_SFIXED32:  wt = WT_I32;
            FT_STRING, FT_MESSAGE, FT_BYTES:    wt = WT_LEN;
            FT_GROUP:                           wt = WT_SGROUP;
            default:                            wt = WT_VARINT;
        endcase
        return wt;
    endfunction

    // Wire types 6/7 are never legal; group markers only when groups are rejected.
    function automatic logic wire_type_illegal(input logic [2:0] wt, input logic reject_groups);
        logic bad;
        case (wt)
            3'd3, 3'd4: bad = reject_groups;
            3'd6, 3'd7: bad = 1'b1;
            default:    bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Priority: too long, then bad wire type, then field number zero.
    function automatic hdr_err_e classify_header(input logic too_long, input logic wt_bad,
                                                 input logic id_zero);
        hdr_err_e err;
        if (too_long) begin
            err = ERR_LONG;
        end else if (wt_bad) begin
            err = ERR_WTYPE;
        end else if (id_zero) begin
            err = ERR_ID0;
        end else begin
            err = ERR_OK;
        end
        return err;
    endfunction

endpackage

// File: rtl/field_header_parser.sv
// Byte-serial decoder for protobuf field headers (tag varints).
// Reassembles tag = (field_id << 3) | wire_type from LSB-first varint bytes and
// presents the decoded header to the dispatcher over valid/ready.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input byte handshake; in_byte[7] = continuation
//   hdr_valid/hdr_ready   decoded header handshake
//   field_id, wire_type   decoded (or, on error, raw accumulated) tag fields
//   hdr_len               bytes consumed by this header
//   hdr_err               0 OK, 1 bad wire type, 2 field id zero, 3 too long
module field_header_parser
    import pb_wire_pkg::*;
#(
    parameter int FIELD_ID_W    = 29,
    parameter bit REJECT_GROUPS = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_byte,
    output logic                  hdr_valid,
    input  logic                  hdr_ready,
    output logic [FIELD_ID_W-1:0] field_id,
    output logic [2:0]            wire_type,
    output logic [2:0]            hdr_len,
    output logic [1:0]            hdr_err
);

    localparam int TAG_W     = FIELD_ID_W + 3;
    localparam int MAX_BYTES = (TAG_W + 6) / 7;
    // Number of payload bits the final byte may legally carry.
    localparam int LAST_BITS = TAG_W - 7 * (MAX_BYTES - 1);
    localparam int CNT_W     = $clog2(MAX_BYTES);

    parse_state_e     state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [TAG_W-1:0] acc_r, acc_s;
    logic [TAG_W-1:0] merged_s;
    logic             drain_r, drain_s;
    logic             take_s, hdr_take_s, drain_take_s;
    logic             first_s, last_s, over_s, long_s, done_s;

    // Input acceptance handshake and the byte classification derived from it.
    always_comb begin
        in_ready     = (state_r != ST_HOLD) || hdr_ready;
        hdr_valid    = (state_r == ST_HOLD);
        take_s       = in_valid && in_ready;
        // In HOLD a byte is only taken together with the header handshake.
        hdr_take_s   = take_s && ((state_r == ST_ACCUM) || ((state_r == ST_HOLD) && !drain_r));
        drain_take_s = take_s && ((state_r == ST_DRAIN) || ((state_r == ST_HOLD) && drain_r));
        // cnt_r is held at zero outside ACCUM, so it is the byte index directly.
        first_s      = (cnt_r == CNT_W'(0));
        last_s       = (cnt_r == CNT_W'(MAX_BYTES - 1));
        over_s       = last_s && ((in_byte[6:0] >> LAST_BITS) != 7'd0);
        long_s       = last_s && (over_s || in_byte[7]);
        done_s       = hdr_take_s && (last_s || !in_byte[7]);
    end

    // Byte-lane merge: byte k lands in tag bits [7k+6:7k]; byte 0 clears older lanes.
    for (genvar i = 0; i < MAX_BYTES; i++) begin : g_lane
        localparam int LW = (i == MAX_BYTES - 1) ? LAST_BITS : 7;
        assign merged_s[7*i +: LW] = (cnt_r == CNT_W'(i)) ? in_byte[LW-1:0] :
                                     (first_s ? {LW{1'b0}} : acc_r[7*i +: LW]);
    end

    // State register with accumulator, byte index and pending-drain flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_ACCUM;
            cnt_r   <= '0;
            acc_r   <= '0;
            drain_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            acc_r   <= acc_s;
            drain_r <= drain_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        acc_s   = acc_r;
        drain_s = drain_r;
        case (state_r)
            ST_ACCUM: begin
                if (hdr_take_s) begin
                    acc_s = merged_s;
                    if (done_s) begin
                        state_s = ST_HOLD;
                        cnt_s   = '0;
                        drain_s = long_s && in_byte[7];
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end else begin
                    state_s = ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (!hdr_ready) begin
                    state_s = ST_HOLD;
                end else if (drain_r) begin
                    // A byte taken alongside the handshake already belongs to the drain.
                    drain_s = 1'b0;
                    if (drain_take_s && !in_byte[7]) begin
                        state_s = ST_ACCUM;
                    end else begin
                        state_s = ST_DRAIN;
                    end
                end else if (hdr_take_s) begin
                    acc_s = merged_s;
                    if (done_s) begin
                        state_s = ST_HOLD;
                        cnt_s   = '0;
                        drain_s = long_s && in_byte[7];
                    end else begin
                        state_s = ST_ACCUM;
                        cnt_s   = CNT_W'(1);
                    end
                end else begin
                    state_s = ST_ACCUM;
                end
            end
            ST_DRAIN: begin
                if (drain_take_s && !in_byte[7]) begin
                    state_s = ST_ACCUM;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_ACCUM;
                cnt_s   = '0;
                acc_s   = '0;
                drain_s = 1'b0;
            end
        endcase
    end

    // Registered header outputs, captured on the byte that completes a header.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            field_id  <= '0;
            wire_type <= 3'd0;
            hdr_len   <= 3'd0;
            hdr_err   <= 2'd0;
        end else if (done_s) begin
            field_id  <= merged_s[3 +: FIELD_ID_W];
            wire_type <= merged_s[2:0];
            hdr_len   <= 3'(cnt_r) + 3'd1;
            hdr_err   <= classify_header(long_s,
                                         wire_type_illegal(merged_s[2:0], REJECT_GROUPS),
                                         merged_s[3 +: FIELD_ID_W] == '0);
        end else begin
            field_id  <= field_id;
            wire_type <= wire_type;
            hdr_len   <= hdr_len;
            hdr_err   <= hdr_err;
        end
    end

endmodule

// File: tb/tb_field_header_parser.sv
// Self-checking bench for field_header_parser: directed spec vectors, stall and
// back-to-back behaviour, reset mid-header, and random streams against a model.
module tb_field_header_parser;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [28:0] fid;
        logic [2:0]  wt;
        logic [2:0]  len;
        logic [1:0]  err1;
        logic [1:0]  err0;
        logic [31:0] cyc;
    } hdr_t;
    typedef hdr_t hdr_q_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        hdr_ready = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_ready, hdr_valid, in_ready0, hdr_valid0;
    logic [28:0] field_id, field_id0;
    logic [2:0]  wire_type, wire_type0, hdr_len, hdr_len0;
    logic [1:0]  hdr_err, hdr_err0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] cyc = 32'd0;
    hdr_q_t      obs_q;

    localparam logic [28:0] EXP_FID [9] = '{29'd1, 29'd150, 29'h1FFFFFFF, 29'h1E000000,
                                            29'd0, 29'd1, 29'd1, 29'd0, 29'd1};
    localparam logic [2:0]  EXP_WT  [9] = '{3'd0, 3'd2, 3'd5, 3'd0, 3'd0, 3'd0, 3'd3, 3'd0, 3'd6};
    localparam logic [2:0]  EXP_LEN [9] = '{3'd1, 3'd2, 3'd5, 3'd5, 3'd5, 3'd1, 3'd1, 3'd1, 3'd1};
    localparam logic [1:0]  EXP_E1  [9] = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd0, 2'd1, 2'd2, 2'd1};
    localparam logic [1:0]  EXP_E0  [9] = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd0, 2'd0, 2'd2, 2'd1};

    field_header_parser #(.FIELD_ID_W(29), .REJECT_GROUPS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .field_id(field_id),
        .wire_type(wire_type), .hdr_len(hdr_len), .hdr_err(hdr_err)
    );

    field_header_parser #(.FIELD_ID_W(29), .REJECT_GROUPS(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_byte(in_byte),
        .hdr_valid(hdr_valid0), .hdr_ready(hdr_ready), .field_id(field_id0),
        .wire_type(wire_type0), .hdr_len(hdr_len0), .hdr_err(hdr_err0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    // Record every header handshake (dut0 contributes its error code only).
    always @(negedge clk) begin
        if (rst_n && hdr_valid && hdr_ready) begin
            obs_q.push_back({field_id, wire_type, hdr_len, hdr_err, hdr_err0, cyc});
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Reference decoder: arithmetic varint reassembly following the header rules.
    function automatic void model_stream(input byte_q_t b, input bit reject, output hdr_q_t q);
        longint unsigned tag = 0;
        int k = 0;
        bit drain = 0;
        q = {};
        foreach (b[i]) begin
            int pay = int'(b[i] & 8'h7F);
            bit cont = b[i][7];
            bit is_long = 0;
            bit emit = 0;
            if (drain) begin
                if (!cont) drain = 0;
            end else begin
                tag = tag + (longint'(pay) << (7 * k));
                if (k == 4 && ((pay >> 4) != 0 || cont)) begin
                    is_long = 1; emit = 1; drain = cont;
                end else if (!cont) begin
                    emit = 1;
                end else begin
                    k++;
                end
                if (emit) begin
                    hdr_t h;
                    longint unsigned fid = (tag >> 3) & 64'h1FFF_FFFF;
                    int wt = int'(tag & 64'h7);
                    h.fid = fid[28:0];
                    h.wt  = 3'(wt);
                    h.len = 3'(k + 1);
                    h.cyc = 32'd0;
                    if (is_long) h.err1 = 2'd3;
                    else if (wt >= 6 || ((wt == 3 || wt == 4) && reject)) h.err1 = 2'd1;
                    else if (fid == 0) h.err1 = 2'd2;
                    else h.err1 = 2'd0;
                    if (is_long) h.err0 = 2'd3;
                    else if (wt >= 6) h.err0 = 2'd1;
                    else if (fid == 0) h.err0 = 2'd2;
                    else h.err0 = 2'd0;
                    q.push_back(h);
                    k = 0;
                    tag = 0;
                end
            end
        end
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; hdr_ready = 1'b0; in_byte = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Drive a byte stream with random valid gaps and random hdr_ready, then drain.
    task automatic run_stream(input byte_q_t bytes, input int vpct, input int rpct);
        int idx = 0;
        int guard = 0;
        while (idx < bytes.size() && guard < 20000) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(99) < vpct);
            in_byte   = in_valid ? bytes[idx] : 8'($urandom());
            hdr_ready = ($urandom_range(99) < rpct);
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            guard++;
        end
        if (idx < bytes.size()) begin
            errors++;
            $display("FAIL stream_timeout: accepted %0d bytes, required %0d", idx, bytes.size());
        end
        @(posedge clk); #1;
        in_valid = 1'b0; hdr_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_byte = 8'hFF; hdr_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (hdr_valid !== 1'b0 || in_ready !== 1'b1 || field_id !== 29'd0 || wire_type !== 3'd0 ||
            hdr_len !== 3'd0 || hdr_err !== 2'd0 || hdr_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: valid=%0b ready=%0b fid=%0d wt=%0d len=%0d err=%0d, required 0 1 0 0 0 0",
                     hdr_valid, in_ready, field_id, wire_type, hdr_len, hdr_err);
        end
    endtask

    task automatic test_latency();
        do_reset();
        in_valid = 1'b1; in_byte = 8'h08; hdr_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (hdr_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL latency_pre: valid=%0b ready=%0b, required 0 1", hdr_valid, in_ready);
        end
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (hdr_valid !== 1'b1 || field_id !== 29'd1 || wire_type !== 3'd0 || hdr_len !== 3'd1 ||
            hdr_err !== 2'd0) begin
            errors++;
            $display("FAIL latency_hdr: valid=%0b fid=%0d wt=%0d len=%0d err=%0d, required 1 1 0 1 0",
                     hdr_valid, field_id, wire_type, hdr_len, hdr_err);
        end
        @(posedge clk); #1 hdr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (hdr_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_release: valid=%0b, required 0", hdr_valid);
        end
    endtask

    task automatic test_directed(input int vpct, input int rpct);
        byte_q_t s = '{8'h08, 8'hB2, 8'h09, 8'hFD, 8'hFF, 8'hFF, 8'hFF, 8'h0F,
                       8'h80, 8'h80, 8'h80, 8'h80, 8'h1F,
                       8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h01, 8'h08,
                       8'h0B, 8'h00, 8'h0E};
        do_reset();
        obs_q.delete();
        run_stream(s, vpct, rpct);
        checks++;
        if (obs_q.size() != 9) begin
            errors++;
            $display("FAIL directed_count: got %0d headers, required 9", obs_q.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (obs_q[i].fid !== EXP_FID[i] || obs_q[i].wt !== EXP_WT[i] ||
                    obs_q[i].len !== EXP_LEN[i] || obs_q[i].err1 !== EXP_E1[i] ||
                    obs_q[i].err0 !== EXP_E0[i]) begin
                    errors++;
                    $display("FAIL directed_hdr%0d: fid=%h wt=%0d len=%0d err=%0d/%0d, required fid=%h wt=%0d len=%0d err=%0d/%0d",
                             i, obs_q[i].fid, obs_q[i].wt, obs_q[i].len, obs_q[i].err1, obs_q[i].err0,
                             EXP_FID[i], EXP_WT[i], EXP_LEN[i], EXP_E1[i], EXP_E0[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [28:0] exp_fid [4] = '{29'd5, 29'd1, 29'd2, 29'd3};
        do_reset();
        obs_q.delete();
        in_valid = 1'b1; in_byte = 8'h28; hdr_ready = 1'b0;
        @(posedge clk); #1 in_byte = 8'h08;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || in_ready0 !== 1'b0 || hdr_valid !== 1'b1 || field_id !== 29'd5 ||
                wire_type !== 3'd0 || hdr_len !== 3'd1 || hdr_err !== 2'd0) begin
                errors++;
                $display("FAIL stall_cycle%0d: ready=%0b valid=%0b fid=%0d wt=%0d len=%0d err=%0d, required 0 1 5 0 1 0",
                         i, in_ready, hdr_valid, field_id, wire_type, hdr_len, hdr_err);
            end
        end
        @(posedge clk); #1 hdr_ready = 1'b1;
        @(posedge clk); #1 in_byte = 8'h10;
        @(posedge clk); #1 in_byte = 8'h18;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs_q.size() != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d headers, required 4", obs_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_q[i].fid !== exp_fid[i] || obs_q[i].err1 !== 2'd0 ||
                    obs_q[i].cyc !== obs_q[0].cyc + 32'(i)) begin
                    errors++;
                    $display("FAIL b2b_hdr%0d: fid=%0d err=%0d cycle_offset=%0d, required fid=%0d err=0 offset=%0d",
                             i, obs_q[i].fid, obs_q[i].err1, obs_q[i].cyc - obs_q[0].cyc, exp_fid[i], i);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid = 1'b1; in_byte = 8'h28; hdr_ready = 1'b0;
        @(posedge clk); #1 in_byte = 8'hB2; hdr_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (hdr_valid !== 1'b0 || in_ready !== 1'b1 || field_id !== 29'd0 || wire_type !== 3'd0 ||
            hdr_len !== 3'd0 || hdr_err !== 2'd0) begin
            errors++;
            $display("FAIL midreset_clear: valid=%0b ready=%0b fid=%0d wt=%0d len=%0d err=%0d, required 0 1 0 0 0 0",
                     hdr_valid, in_ready, field_id, wire_type, hdr_len, hdr_err);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        obs_q.delete();
        in_valid = 1'b1; in_byte = 8'h08;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs_q.size() != 1 || obs_q[0].fid !== 29'd1 || obs_q[0].wt !== 3'd0 ||
            obs_q[0].len !== 3'd1 || obs_q[0].err1 !== 2'd0) begin
            errors++;
            $display("FAIL midreset_next: headers=%0d fid=%0d len=%0d err=%0d, required 1 header fid=1 len=1 err=0",
                     obs_q.size(), obs_q.size() > 0 ? obs_q[0].fid : 29'd0,
                     obs_q.size() > 0 ? obs_q[0].len : 3'd0, obs_q.size() > 0 ? obs_q[0].err1 : 2'd0);
        end
    endtask

    task automatic test_random(input int n, input int vpct, input int rpct);
        byte_q_t s;
        hdr_q_t  exp_q;
        for (int h = 0; h < n; h++) begin
            int r = int'($urandom_range(9));
            if (r == 0) begin
                int len = int'($urandom_range(7, 5));
                for (int j = 0; j < len; j++) s.push_back(8'h80 | 8'($urandom()));
                s.push_back(8'($urandom()) & 8'h7F);
            end else if (r == 1) begin
                for (int j = 0; j < 4; j++) s.push_back(8'h80 | 8'($urandom()));
                s.push_back(8'($urandom_range(127, 16)));
            end else begin
                logic [31:0] mask = (32'h1 << $urandom_range(29, 1)) - 32'h1;
                logic [31:0] fid = (r == 2) ? 32'h0 : ($urandom() & mask);
                logic [31:0] tag = {fid[28:0], 3'($urandom_range(7))};
                do begin
                    logic [7:0] b = {1'b0, tag[6:0]};
                    tag = tag >> 7;
                    if (tag != 32'h0) b[7] = 1'b1;
                    s.push_back(b);
                end while (tag != 32'h0);
            end
        end
        s.push_back(8'h08);
        model_stream(s, 1'b1, exp_q);
        do_reset();
        obs_q.delete();
        run_stream(s, vpct, rpct);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL random_count: got %0d headers, required %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i].fid !== exp_q[i].fid || obs_q[i].wt !== exp_q[i].wt ||
                    obs_q[i].len !== exp_q[i].len || obs_q[i].err1 !== exp_q[i].err1 ||
                    obs_q[i].err0 !== exp_q[i].err0) begin
                    errors++;
                    $display("FAIL random_hdr%0d: fid=%h wt=%0d len=%0d err=%0d/%0d, required fid=%h wt=%0d len=%0d err=%0d/%0d",
                             i, obs_q[i].fid, obs_q[i].wt, obs_q[i].len, obs_q[i].err1, obs_q[i].err0,
                             exp_q[i].fid, exp_q[i].wt, exp_q[i].len, exp_q[i].err1, exp_q[i].err0);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_directed(100, 100);
        test_directed(60, 50);
        test_back_to_back();
        test_reset_mid();
        test_random(300, 100, 100);
        test_random(300, 70, 60);
        test_random(300, 40, 90);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
